// File: rtl/cacheline_adaptor.sv
// Memory-side responder for the cache line port: turns each line fill or writeback
// into a BEATS-beat burst on the narrow memory bus and pulses pmem_resp on completion.
`timescale 1ns/1ps

module cacheline_adaptor #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned BEATS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [ADDR_W-1:0]         pmem_address,
    input  logic                      pmem_read,
    input  logic                      pmem_write,
    input  logic [BEAT_W*BEATS-1:0]   pmem_wdata,
    output logic [BEAT_W*BEATS-1:0]   pmem_rdata,
    output logic                      pmem_resp,

    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [BEAT_W-1:0]         mem_wdata,
    input  logic [BEAT_W-1:0]         mem_rdata,
    input  logic                      mem_resp
);

    localparam int unsigned LINE_W = BEAT_W * BEATS;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   pmem_rdata_q;
    logic                pmem_resp_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [BEAT_W-1:0]   mem_wdata_q;

    logic [CNT_W-1:0]    cnt_nxt;
    logic                last_beat;
    logic [ADDR_W-1:0]   aligned_addr;
    logic                unused_addr_bits;

    assign cnt_nxt          = cnt_q + CNT_W'(1);
    assign last_beat        = (cnt_q == CNT_W'(BEATS - 1));
    assign aligned_addr     = {pmem_address[ADDR_W-1:OFF_W], OFF_W'(0)};
    // Byte offset within the line is dropped by alignment.
    assign unused_addr_bits = ^pmem_address[OFF_W-1:0];

    // Burst sequencer; every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            line_q        <= '0;
            pmem_rdata_q  <= '0;
            pmem_resp_q   <= 1'b0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            pmem_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Writeback wins so a dirty victim leaves before the fill arrives.
                    if (pmem_write) begin
                        line_q        <= pmem_wdata;
                        mem_wdata_q   <= pmem_wdata[BEAT_W-1:0];
                        mem_address_q <= aligned_addr;
                        cnt_q         <= '0;
                        mem_write_q   <= 1'b1;
                        state_q       <= WR_BURST;
                    end else if (pmem_read) begin
                        mem_address_q <= aligned_addr;
                        cnt_q         <= '0;
                        mem_read_q    <= 1'b1;
                        state_q       <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (mem_resp) begin
                        pmem_rdata_q[BEAT_W*32'(cnt_q) +: BEAT_W] <= mem_rdata;
                        cnt_q <= cnt_nxt;
                        if (last_beat) begin
                            mem_read_q  <= 1'b0;
                            pmem_resp_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (mem_resp) begin
                        cnt_q <= cnt_nxt;
                        if (last_beat) begin
                            mem_write_q <= 1'b0;
                            pmem_resp_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            mem_wdata_q <= line_q[BEAT_W*32'(cnt_nxt) +: BEAT_W];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata  = pmem_rdata_q;
    assign pmem_resp   = pmem_resp_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a reactive memory model answers bursts,
// expected beats/lines are queued at request time and checked as the DUT produces them.
`timescale 1ns/1ps

module tb_cacheline_adaptor;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned LINE_W = BEAT_W * BEATS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [ADDR_W-1:0]   pmem_address;
    logic                pmem_read;
    logic                pmem_write;
    logic [LINE_W-1:0]   pmem_wdata;
    logic [LINE_W-1:0]   pmem_rdata;
    logic                pmem_resp;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [BEAT_W-1:0]   mem_wdata;
    logic [BEAT_W-1:0]   mem_rdata;
    logic                mem_resp;

    cacheline_adaptor #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_rd;
        logic [LINE_W-1:0] line;
    } cmpl_t;

    cmpl_t             cq[$];
    logic [BEAT_W-1:0] wq[$];
    cmpl_t             cur;
    logic [BEAT_W-1:0] rd_beats [BEATS];
    logic [ADDR_W-1:0] exp_addr = '0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   req_cyc = 0;
    int   resp_seen = 0;
    int   resp_cyc = 0;
    int   overlap = 0;
    int   gap = 0;
    int   idle_cnt = 0;
    bit   stray = 1'b0;
    logic [1:0] ridx = '0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rd_line();
        return {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
    endfunction

    task automatic set_beats(input logic [BEAT_W-1:0] b0, input logic [BEAT_W-1:0] b1,
                             input logic [BEAT_W-1:0] b2, input logic [BEAT_W-1:0] b3);
        rd_beats[0] = b0;
        rd_beats[1] = b1;
        rd_beats[2] = b2;
        rd_beats[3] = b3;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (resp_seen >= target) return;
        end
        check("resp_timeout", LINE_W'(resp_seen), LINE_W'(target));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers a beat after 'gap' idle cycles while a burst is active.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_resp = 1'b0;
            ridx     = '0;
            idle_cnt = 0;
        end else if (stray) begin
            mem_resp = 1'b1;
        end else if (mem_read || mem_write) begin
            if (idle_cnt >= gap) begin
                mem_resp  = 1'b1;
                mem_rdata = rd_beats[ridx];
                ridx      = ridx + 2'd1;
                idle_cnt  = 0;
            end else begin
                mem_resp = 1'b0;
                idle_cnt++;
            end
        end else begin
            mem_resp = 1'b0;
            idle_cnt = 0;
        end
    end

    // Monitor: compares bus activity and completions against the queued expectations.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (mem_read && mem_write) overlap++;
            if (mem_read || mem_write) check("mem_address", LINE_W'(mem_address), LINE_W'(exp_addr));
            if (mem_write) begin
                check("wq_nonempty", LINE_W'(wq.size() != 0), LINE_W'(1));
                if (wq.size() != 0) begin
                    if (mem_resp) check("wdata_beat", LINE_W'(mem_wdata), LINE_W'(wq.pop_front()));
                    else          check("wdata_hold", LINE_W'(mem_wdata), LINE_W'(wq[0]));
                end
            end
            if (pmem_resp) begin
                resp_seen++;
                resp_cyc = cyc;
                check("cq_nonempty", LINE_W'(cq.size() != 0), LINE_W'(1));
                if (cq.size() != 0) begin
                    cur = cq.pop_front();
                    if (cur.is_rd) check("pmem_rdata", pmem_rdata, cur.line);
                end
            end
        end
    end

    initial begin
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        mem_rdata    = '0;
        mem_resp     = 1'b0;
        set_beats('0, '0, '0, '0);

        repeat (2) @(negedge clk);
        #1;
        check("rst_pmem_resp", LINE_W'(pmem_resp), '0);
        check("rst_pmem_rdata", pmem_rdata, '0);
        check("rst_mem_rw", LINE_W'({mem_read, mem_write}), '0);
        check("rst_mem_address", LINE_W'(mem_address), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill with back-to-back beats.
        set_beats({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
        gap      = 0;
        exp_addr = 32'h1234_5660;
        cq.push_back('{1'b1, rd_line()});
        pmem_address = 32'h1234_5678;
        pmem_read    = 1'b1;
        req_cyc      = cyc;
        @(negedge clk);
        #2;
        check("fill_mem_read", LINE_W'(mem_read), LINE_W'(1));
        check("fill_mem_write", LINE_W'(mem_write), '0);
        wait_resp(1);
        pmem_read = 1'b0;
        check("fill_latency", LINE_W'(resp_cyc - req_cyc), LINE_W'(5));
        check("fill_line", pmem_rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        @(negedge clk);
        #2;
        check("fill_resp_pulse", LINE_W'(pmem_resp), '0);
        check("fill_rdata_stable", pmem_rdata, rd_line());

        // Writeback with two idle cycles before each beat.
        gap      = 2;
        exp_addr = 32'hCAFE_BAA0;
        wq.push_back(64'hD0D0_0000_0000_00D0);
        wq.push_back(64'hD1D1_1111_1111_11D1);
        wq.push_back(64'hD2D2_2222_2222_22D2);
        wq.push_back(64'hD3D3_3333_3333_33D3);
        cq.push_back('{1'b0, '0});
        pmem_address = 32'hCAFE_BABF;
        pmem_wdata   = {64'hD3D3_3333_3333_33D3, 64'hD2D2_2222_2222_22D2,
                        64'hD1D1_1111_1111_11D1, 64'hD0D0_0000_0000_00D0};
        pmem_write   = 1'b1;
        wait_resp(2);
        pmem_write = 1'b0;
        check("wb_beats_consumed", LINE_W'(wq.size()), '0);
        check("wb_mem_write_low", LINE_W'(mem_write), '0);
        @(negedge clk);
        #2;
        check("wb_resp_pulse", LINE_W'(pmem_resp), '0);

        // Read and write together: writeback first, held read follows.
        gap      = 1;
        exp_addr = 32'h0000_1040;
        set_beats(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0);
        wq.push_back(64'hAAAA_0000_0000_0001);
        wq.push_back(64'hAAAA_0000_0000_0002);
        wq.push_back(64'hAAAA_0000_0000_0003);
        wq.push_back(64'hAAAA_0000_0000_0004);
        cq.push_back('{1'b0, '0});
        cq.push_back('{1'b1, rd_line()});
        pmem_address = 32'h0000_105C;
        pmem_wdata   = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
                        64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        @(negedge clk);
        #2;
        check("both_write_first", LINE_W'({mem_write, mem_read}), LINE_W'(2'b10));
        wait_resp(3);
        pmem_write = 1'b0;
        @(negedge clk);
        #2;
        @(negedge clk);
        #2;
        check("held_read_start", LINE_W'({mem_write, mem_read}), LINE_W'(2'b01));
        wait_resp(4);
        pmem_read = 1'b0;

        // Asynchronous reset after two of four read beats.
        gap      = 0;
        exp_addr = 32'h8000_0000;
        set_beats(64'hBAD0_BAD0_BAD0_BAD0, 64'hBAD1_BAD1_BAD1_BAD1,
                  64'hBAD2_BAD2_BAD2_BAD2, 64'hBAD3_BAD3_BAD3_BAD3);
        cq.push_back('{1'b1, rd_line()});
        @(negedge clk);
        pmem_address = 32'h8000_0010;
        pmem_read    = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_mem_rw", LINE_W'({mem_read, mem_write}), '0);
        check("arst_pmem_resp", LINE_W'(pmem_resp), '0);
        check("arst_pmem_rdata", pmem_rdata, '0);
        check("arst_mem_address", LINE_W'(mem_address), '0);
        check("arst_mem_wdata", LINE_W'(mem_wdata), '0);
        cq.delete();
        pmem_read = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        exp_addr = 32'h4444_0020;
        set_beats(64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002,
                  64'h3000_0000_0000_0003, 64'h4000_0000_0000_0004);
        cq.push_back('{1'b1, rd_line()});
        pmem_address = 32'h4444_0033;
        pmem_read    = 1'b1;
        wait_resp(5);
        pmem_read = 1'b0;

        // Stray mem_resp while idle must be ignored.
        @(negedge clk);
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("stray_pmem_resp", LINE_W'(pmem_resp), '0);
            check("stray_mem_rw", LINE_W'({mem_read, mem_write}), '0);
        end
        stray    = 1'b0;
        exp_addr = 32'h0BAD_F000;
        set_beats(64'hC0C0_C0C0_0000_0000, 64'hC1C1_C1C1_1111_1111,
                  64'hC2C2_C2C2_2222_2222, 64'hC3C3_C3C3_3333_3333);
        cq.push_back('{1'b1, rd_line()});
        @(negedge clk);
        pmem_address = 32'h0BAD_F01F;
        pmem_read    = 1'b1;
        req_cyc      = cyc;
        wait_resp(6);
        pmem_read = 1'b0;
        check("stray_latency", LINE_W'(resp_cyc - req_cyc), LINE_W'(5));

        // Request dropped after the first beat still completes.
        exp_addr = 32'h7777_7740;
        set_beats(64'hE0E0_0000_0000_E0E0, 64'hE1E1_0000_0000_E1E1,
                  64'hE2E2_0000_0000_E2E2, 64'hE3E3_0000_0000_E3E3);
        cq.push_back('{1'b1, rd_line()});
        @(negedge clk);
        pmem_address = 32'h7777_7744;
        pmem_read    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        pmem_read = 1'b0;
        wait_resp(7);
        repeat (3) begin
            @(negedge clk);
            #2;
            check("drop_idle", LINE_W'({mem_read, mem_write, pmem_resp}), '0);
        end
        check("drop_resp_count", LINE_W'(resp_seen), LINE_W'(7));

        check("end_wq_empty", LINE_W'(wq.size()), '0);
        check("end_cq_empty", LINE_W'(cq.size()), '0);
        check("rw_exclusive", LINE_W'(overlap), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
